// File: rtl/tpu_cmd_pkg.sv
// ----------------------------------------------------------------------------
// tpu_cmd_pkg
// Shared definitions for the TPU tile command port. Both the host-side issuer
// and the control unit import this package, so the command layout lives here.
//   command_t      : packed tile command, addr_d in the MSBs, len_m in the LSBs
//   issuer_state_t : issuer FSM encoding
//   tile_len()     : length of a tile edge given the remaining extent
// ----------------------------------------------------------------------------
package tpu_cmd_pkg;

    localparam int CMD_ADDR_WIDTH      = 10;
    localparam int TILE_W              = 16;
    localparam int CMD_MAX_OUTSTANDING = 4;
    localparam int LEN_WIDTH           = 8;
    localparam int CMD_WIDTH           = 64;
    localparam int OUT_WIDTH           = $clog2(CMD_MAX_OUTSTANDING + 1);

    // Field order matches cmd_data bit order (first field = MSBs).
    typedef struct packed {
        logic [CMD_ADDR_WIDTH-1:0] addr_d;
        logic [CMD_ADDR_WIDTH-1:0] addr_c;
        logic [CMD_ADDR_WIDTH-1:0] addr_b;
        logic [CMD_ADDR_WIDTH-1:0] addr_a;
        logic [LEN_WIDTH-1:0]      len_n;
        logic [LEN_WIDTH-1:0]      len_k;
        logic [LEN_WIDTH-1:0]      len_m;
    } command_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2
    } issuer_state_t;

    // Tile edge length: a full tile unless fewer rows/cols remain.
    function automatic logic [LEN_WIDTH-1:0] tile_len(input logic [LEN_WIDTH-1:0] remainder);
        if (remainder > LEN_WIDTH'(TILE_W)) begin
            return LEN_WIDTH'(TILE_W);
        end else begin
            return remainder;
        end
    endfunction

endpackage

// File: rtl/tile_cmd_issuer_if.sv
// ----------------------------------------------------------------------------
// tile_cmd_issuer_if
// Bundles the job request side (host/CSR front-end) and the command stream
// side (control unit) of the tile command issuer.
//   job_*        : job request and its result pulses
//   cmd_*        : valid/ready tile command stream, 64-bit payload
//   done_irq     : one pulse per completed tile from the control unit
//   outstanding  : tiles issued but not yet completed
//   issuer_busy  : issuer is working on a job
// modport master : the issuer's view; modport slave : the environment's view
// ----------------------------------------------------------------------------
interface tile_cmd_issuer_if
    import tpu_cmd_pkg::*;
#(
    parameter int ADDR_WIDTH = CMD_ADDR_WIDTH,
    parameter int CNT_WIDTH  = OUT_WIDTH
);
    logic                   job_valid;
    logic                   job_ready;
    logic [LEN_WIDTH-1:0]   job_dim_m;
    logic [LEN_WIDTH-1:0]   job_dim_n;
    logic [LEN_WIDTH-1:0]   job_dim_k;
    logic [ADDR_WIDTH-1:0]  job_base_a;
    logic [ADDR_WIDTH-1:0]  job_base_b;
    logic [ADDR_WIDTH-1:0]  job_base_c;
    logic [ADDR_WIDTH-1:0]  job_base_d;
    logic                   cmd_valid;
    logic [CMD_WIDTH-1:0]   cmd_data;
    logic                   cmd_ready;
    logic                   done_irq;
    logic                   job_done;
    logic                   job_err;
    logic [CNT_WIDTH-1:0]   outstanding;
    logic                   issuer_busy;

    modport master (
        input  job_valid, job_dim_m, job_dim_n, job_dim_k,
        input  job_base_a, job_base_b, job_base_c, job_base_d,
        input  cmd_ready, done_irq,
        output job_ready, cmd_valid, cmd_data,
        output job_done, job_err, outstanding, issuer_busy
    );

    modport slave (
        output job_valid, job_dim_m, job_dim_n, job_dim_k,
        output job_base_a, job_base_b, job_base_c, job_base_d,
        output cmd_ready, done_irq,
        input  job_ready, cmd_valid, cmd_data,
        input  job_done, job_err, outstanding, issuer_busy
    );

endinterface

// File: rtl/tile_cmd_issuer_walker.sv
// ----------------------------------------------------------------------------
// tile_walker
// Walks the M x N output tile grid in row-major order (n inner, m outer) and
// presents the current tile as a command_t. Addresses advance by W per step,
// wrapping modulo 2^ADDR_WIDTH; no multipliers.
//   clk, rst        : clock, async active-high reset
//   load            : capture a new job; the tile view shows tile (0,0) this cycle
//   advance         : step to the next tile at the clock edge
//   dim_*, base_*   : job fields, sampled when load = 1
//   tile_cmd        : current tile command (combinational)
//   last_tile       : current tile is the final tile of the job
// load and advance may be asserted together: tile (0,0) is consumed at once.
// ----------------------------------------------------------------------------
module tile_walker
    import tpu_cmd_pkg::*;
#(
    parameter int ADDR_WIDTH = CMD_ADDR_WIDTH,
    parameter int W          = TILE_W
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   load,
    input  logic                   advance,
    input  logic [LEN_WIDTH-1:0]   dim_m,
    input  logic [LEN_WIDTH-1:0]   dim_n,
    input  logic [LEN_WIDTH-1:0]   dim_k,
    input  logic [ADDR_WIDTH-1:0]  base_a,
    input  logic [ADDR_WIDTH-1:0]  base_b,
    input  logic [ADDR_WIDTH-1:0]  base_c,
    input  logic [ADDR_WIDTH-1:0]  base_d,
    output command_t               tile_cmd,
    output logic                   last_tile
);

    localparam logic [ADDR_WIDTH-1:0] ADDR_STEP = ADDR_WIDTH'(W);
    localparam logic [LEN_WIDTH-1:0]  LEN_STEP  = LEN_WIDTH'(W);

    typedef struct packed {
        logic [LEN_WIDTH-1:0]  m_idx;
        logic [LEN_WIDTH-1:0]  n_idx;
        logic [LEN_WIDTH-1:0]  tiles_m;
        logic [LEN_WIDTH-1:0]  tiles_n;
        logic [LEN_WIDTH-1:0]  rem_m;   // dim_m - m_idx*W
        logic [LEN_WIDTH-1:0]  rem_n;   // dim_n - n_idx*W
        logic [LEN_WIDTH-1:0]  dim_n;
        logic [LEN_WIDTH-1:0]  dim_k;
        logic [ADDR_WIDTH-1:0] base_b;
        logic [ADDR_WIDTH-1:0] addr_a;
        logic [ADDR_WIDTH-1:0] addr_b;
        logic [ADDR_WIDTH-1:0] addr_c;
        logic [ADDR_WIDTH-1:0] addr_d;
    } walk_t;

    walk_t walk_r;
    walk_t cur_s;
    walk_t nxt_s;

    // ceil(dim / W)
    function automatic logic [LEN_WIDTH-1:0] tile_count(input logic [LEN_WIDTH-1:0] dim);
        logic [LEN_WIDTH:0] sum;
        sum = {1'b0, dim} + (LEN_WIDTH + 1)'(W - 1);
        return LEN_WIDTH'(sum / (LEN_WIDTH + 1)'(W));
    endfunction

    // Current tile view: a fresh job bypasses the registers so tile (0,0) is usable immediately.
    always_comb begin
        cur_s = walk_r;
        if (load) begin
            cur_s.m_idx   = 8'd0;
            cur_s.n_idx   = 8'd0;
            cur_s.tiles_m = tile_count(dim_m);
            cur_s.tiles_n = tile_count(dim_n);
            cur_s.rem_m   = dim_m;
            cur_s.rem_n   = dim_n;
            cur_s.dim_n   = dim_n;
            cur_s.dim_k   = dim_k;
            cur_s.base_b  = base_b;
            cur_s.addr_a  = base_a;
            cur_s.addr_b  = base_b;
            cur_s.addr_c  = base_c;
            cur_s.addr_d  = base_d;
        end else begin
            cur_s = walk_r;
        end
    end

    // Next tile: C/D step every tile; A steps and B rewinds when a tile row completes.
    always_comb begin
        nxt_s = cur_s;
        if (advance) begin
            nxt_s.addr_c = cur_s.addr_c + ADDR_STEP;
            nxt_s.addr_d = cur_s.addr_d + ADDR_STEP;
            if (cur_s.n_idx == (cur_s.tiles_n - 8'd1)) begin
                nxt_s.n_idx  = 8'd0;
                nxt_s.m_idx  = cur_s.m_idx + 8'd1;
                nxt_s.rem_n  = cur_s.dim_n;
                nxt_s.rem_m  = cur_s.rem_m - LEN_STEP;
                nxt_s.addr_a = cur_s.addr_a + ADDR_STEP;
                nxt_s.addr_b = cur_s.base_b;
            end else begin
                nxt_s.n_idx  = cur_s.n_idx + 8'd1;
                nxt_s.rem_n  = cur_s.rem_n - LEN_STEP;
                nxt_s.addr_b = cur_s.addr_b + ADDR_STEP;
            end
        end else begin
            nxt_s = cur_s;
        end
    end

    // Walker state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            walk_r <= '0;
        end else begin
            walk_r <= nxt_s;
        end
    end

    // Command fields and last-tile flag for the current tile.
    always_comb begin
        tile_cmd.addr_d = cur_s.addr_d;
        tile_cmd.addr_c = cur_s.addr_c;
        tile_cmd.addr_b = cur_s.addr_b;
        tile_cmd.addr_a = cur_s.addr_a;
        tile_cmd.len_n  = tile_len(cur_s.rem_n);
        tile_cmd.len_k  = cur_s.dim_k;
        tile_cmd.len_m  = tile_len(cur_s.rem_m);
        last_tile       = (cur_s.m_idx == (cur_s.tiles_m - 8'd1)) &&
                          (cur_s.n_idx == (cur_s.tiles_n - 8'd1));
    end

endmodule

// File: rtl/tile_cmd_issuer.sv
// ----------------------------------------------------------------------------
// tile_cmd_issuer
// Splits one GEMM job into WxW tile commands for the TPU control unit, keeps
// at most MAX_OUTSTANDING tiles in flight and reports job completion.
//   clk  : clock
//   rst  : asynchronous active-high reset (drops any job in progress)
//   bus  : tile_cmd_issuer_if.master -- job request, command stream,
//          done_irq, job_done/job_err pulses, outstanding count, busy flag
// All outputs are registered. Flow: IDLE -> ISSUE -> DRAIN -> IDLE.
// ----------------------------------------------------------------------------
module tile_cmd_issuer
    import tpu_cmd_pkg::*;
#(
    parameter int ADDR_WIDTH           = CMD_ADDR_WIDTH,
    parameter int SYSTOLIC_ARRAY_WIDTH = TILE_W,
    parameter int MAX_OUTSTANDING      = CMD_MAX_OUTSTANDING
) (
    input  logic            clk,
    input  logic            rst,
    tile_cmd_issuer_if.master bus
);

    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

    // The command layout only closes at 64 bits for the package geometry.
    if (((4 * ADDR_WIDTH) + 24) != CMD_WIDTH || ADDR_WIDTH != CMD_ADDR_WIDTH ||
        SYSTOLIC_ARRAY_WIDTH != TILE_W) begin : g_bad_cfg
        $error("tile_cmd_issuer: unsupported ADDR_WIDTH/SYSTOLIC_ARRAY_WIDTH");
    end

    issuer_state_t        state_r;
    issuer_state_t        state_s;
    logic [CNT_W-1:0]     outstanding_r;
    logic [CNT_W-1:0]     cnt_nxt_s;
    logic [CNT_W:0]       committed_s;
    command_t             cmd_r;
    logic                 cmd_valid_r;
    logic                 cmd_last_r;
    logic                 all_loaded_r;
    logic                 job_ready_r;
    logic                 job_err_r;
    logic                 job_done_r;
    logic                 issuer_busy_r;

    logic                 accept_s;
    logic                 job_bad_s;
    logic                 xfer_s;
    logic                 done_s;
    logic                 room_s;
    logic                 slot_free_s;
    logic                 start_s;
    logic                 issue_s;
    logic                 job_err_s;
    logic                 job_done_s;
    command_t             tile_cmd_s;
    logic                 last_tile_s;

    tile_walker #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .W          (SYSTOLIC_ARRAY_WIDTH)
    ) u_walker (
        .clk       (clk),
        .rst       (rst),
        .load      (start_s),
        .advance   (issue_s),
        .dim_m     (bus.job_dim_m),
        .dim_n     (bus.job_dim_n),
        .dim_k     (bus.job_dim_k),
        .base_a    (bus.job_base_a),
        .base_b    (bus.job_base_b),
        .base_c    (bus.job_base_c),
        .base_d    (bus.job_base_d),
        .tile_cmd  (tile_cmd_s),
        .last_tile (last_tile_s)
    );

    // Handshake decode and outstanding arithmetic.
    always_comb begin
        accept_s    = bus.job_valid && job_ready_r;
        job_bad_s   = (bus.job_dim_m == 8'd0) || (bus.job_dim_n == 8'd0) ||
                      (bus.job_dim_k == 8'd0) ||
                      (bus.job_dim_k > LEN_WIDTH'(SYSTOLIC_ARRAY_WIDTH));
        xfer_s      = cmd_valid_r && bus.cmd_ready;
        // A done_irq with nothing in flight is ignored.
        done_s      = bus.done_irq && (outstanding_r != {CNT_W{1'b0}});
        cnt_nxt_s   = outstanding_r + CNT_W'(xfer_s) - CNT_W'(done_s);
        // Count after this edge, ignoring any same-cycle done_irq; a new
        // command may only be loaded if that still leaves room.
        committed_s = {1'b0, outstanding_r} + (CNT_W + 1)'(xfer_s);
        room_s      = committed_s < (CNT_W + 1)'(MAX_OUTSTANDING);
        slot_free_s = !cmd_valid_r || xfer_s;
    end

    // FSM next state and per-cycle control.
    always_comb begin
        state_s    = state_r;
        start_s    = 1'b0;
        issue_s    = 1'b0;
        job_err_s  = 1'b0;
        job_done_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (accept_s && job_bad_s) begin
                    job_err_s = 1'b1;
                end else if (accept_s) begin
                    // Tile (0,0) goes straight into the output register.
                    start_s = 1'b1;
                    issue_s = 1'b1;
                    state_s = ST_ISSUE;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                issue_s = !all_loaded_r && slot_free_s && room_s;
                if (xfer_s && cmd_last_r) begin
                    state_s = ST_DRAIN;
                end else begin
                    state_s = ST_ISSUE;
                end
            end
            ST_DRAIN: begin
                if (cnt_nxt_s == {CNT_W{1'b0}}) begin
                    state_s    = ST_IDLE;
                    job_done_s = 1'b1;
                end else begin
                    state_s = ST_DRAIN;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Tiles in flight: +1 per transfer, -1 per accepted done_irq.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            outstanding_r <= {CNT_W{1'b0}};
        end else begin
            outstanding_r <= cnt_nxt_s;
        end
    end

    // Command output register; holds until the control unit takes it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cmd_r        <= '0;
            cmd_valid_r  <= 1'b0;
            cmd_last_r   <= 1'b0;
            all_loaded_r <= 1'b0;
        end else if (issue_s) begin
            cmd_r        <= tile_cmd_s;
            cmd_valid_r  <= 1'b1;
            cmd_last_r   <= last_tile_s;
            all_loaded_r <= last_tile_s;
        end else if (xfer_s) begin
            cmd_valid_r  <= 1'b0;
        end else begin
            cmd_valid_r  <= cmd_valid_r;
        end
    end

    // Job status outputs and result pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            job_ready_r   <= 1'b1;
            issuer_busy_r <= 1'b0;
            job_err_r     <= 1'b0;
            job_done_r    <= 1'b0;
        end else begin
            job_ready_r   <= (state_s == ST_IDLE);
            issuer_busy_r <= (state_s != ST_IDLE);
            job_err_r     <= job_err_s;
            job_done_r    <= job_done_s;
        end
    end

    assign bus.job_ready   = job_ready_r;
    assign bus.cmd_valid   = cmd_valid_r;
    assign bus.cmd_data    = cmd_r;
    assign bus.job_done    = job_done_r;
    assign bus.job_err     = job_err_r;
    assign bus.outstanding = outstanding_r;
    assign bus.issuer_busy = issuer_busy_r;

endmodule

// File: tb/tb_tile_cmd_issuer.sv
// ----------------------------------------------------------------------------
// tb_tile_cmd_issuer
// Directed bench for tile_cmd_issuer: hand-computed tile commands, the
// outstanding limit, backpressure, rejected jobs, address wrap and async reset.
// ----------------------------------------------------------------------------
module tb_tile_cmd_issuer;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    logic [63:0] exp6 [6];

    tile_cmd_issuer_if #(.ADDR_WIDTH(10), .CNT_WIDTH(3)) bus ();

    tile_cmd_issuer #(
        .ADDR_WIDTH           (10),
        .SYSTOLIC_ARRAY_WIDTH (16),
        .MAX_OUTSTANDING      (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] mk_cmd(input logic [9:0] d, input logic [9:0] c,
                                           input logic [9:0] b, input logic [9:0] a,
                                           input logic [7:0] n, input logic [7:0] k,
                                           input logic [7:0] m);
        return {d, c, b, a, n, k, m};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_job(input logic [7:0] m, input logic [7:0] n, input logic [7:0] k,
                           input logic [9:0] a, input logic [9:0] b,
                           input logic [9:0] c, input logic [9:0] d);
        bus.job_dim_m  = m;
        bus.job_dim_n  = n;
        bus.job_dim_k  = k;
        bus.job_base_a = a;
        bus.job_base_b = b;
        bus.job_base_c = c;
        bus.job_base_d = d;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        bus.job_valid = 1'b0;
        bus.cmd_ready = 1'b0;
        bus.done_irq  = 1'b0;
        set_job(8'd0, 8'd0, 8'd0, 10'h000, 10'h000, 10'h000, 10'h000);

        // 40x20x8 job, bases A=0x000 B=0x040 C=0x080 D=0x200
        exp6[0] = mk_cmd(10'h200, 10'h080, 10'h040, 10'h000, 8'd16, 8'd8, 8'd16);
        exp6[1] = mk_cmd(10'h210, 10'h090, 10'h050, 10'h000, 8'd4,  8'd8, 8'd16);
        exp6[2] = mk_cmd(10'h220, 10'h0A0, 10'h040, 10'h010, 8'd16, 8'd8, 8'd16);
        exp6[3] = mk_cmd(10'h230, 10'h0B0, 10'h050, 10'h010, 8'd4,  8'd8, 8'd16);
        exp6[4] = mk_cmd(10'h240, 10'h0C0, 10'h040, 10'h020, 8'd16, 8'd8, 8'd8);
        exp6[5] = mk_cmd(10'h250, 10'h0D0, 10'h050, 10'h020, 8'd4,  8'd8, 8'd8);

        // ---- reset state ----
        tick();
        tick();
        chk("rst_job_ready",   64'(bus.job_ready),   64'd1);
        chk("rst_cmd_valid",   64'(bus.cmd_valid),   64'd0);
        chk("rst_cmd_data",    bus.cmd_data,         64'd0);
        chk("rst_outstanding", 64'(bus.outstanding), 64'd0);
        chk("rst_busy",        64'(bus.issuer_busy), 64'd0);
        chk("rst_job_done",    64'(bus.job_done),    64'd0);
        chk("rst_job_err",     64'(bus.job_err),     64'd0);
        rst = 1'b0;
        tick();

        // ---- single-tile job ----
        set_job(8'd16, 8'd16, 8'd16, 10'h010, 10'h100, 10'h200, 10'h300);
        bus.cmd_ready = 1'b1;
        bus.job_valid = 1'b1;
        tick();
        bus.job_valid = 1'b0;
        chk("t1_valid", 64'(bus.cmd_valid), 64'd1);
        chk("t1_data",  bus.cmd_data,
            mk_cmd(10'h300, 10'h200, 10'h100, 10'h010, 8'd16, 8'd16, 8'd16));
        chk("t1_job_ready_low", 64'(bus.job_ready),   64'd0);
        chk("t1_busy",          64'(bus.issuer_busy), 64'd1);
        tick();
        chk("t1_valid_after_xfer", 64'(bus.cmd_valid),   64'd0);
        chk("t1_outstanding",      64'(bus.outstanding), 64'd1);
        chk("t1_no_early_done",    64'(bus.job_done),    64'd0);
        bus.done_irq = 1'b1;
        tick();
        bus.done_irq = 1'b0;
        chk("t1_job_done",  64'(bus.job_done),    64'd1);
        chk("t1_job_ready", 64'(bus.job_ready),   64'd1);
        chk("t1_out_zero",  64'(bus.outstanding), 64'd0);
        chk("t1_not_busy",  64'(bus.issuer_busy), 64'd0);
        tick();
        chk("t1_done_pulse", 64'(bus.job_done), 64'd0);

        // ---- 6-tile job: ordering, limit, coincident done, backpressure ----
        set_job(8'd40, 8'd20, 8'd8, 10'h000, 10'h040, 10'h080, 10'h200);
        bus.job_valid = 1'b1;
        tick();
        bus.job_valid = 1'b0;
        chk("t2_tile0", bus.cmd_data, exp6[0]);
        chk("t2_out0",  64'(bus.outstanding), 64'd0);
        for (int i = 1; i < 4; i++) begin
            tick();
            chk($sformatf("t2_tile%0d", i), bus.cmd_data, exp6[i]);
            chk($sformatf("t2_valid%0d", i), 64'(bus.cmd_valid), 64'd1);
            chk($sformatf("t2_out%0d", i), 64'(bus.outstanding), 64'(i));
        end
        tick();
        chk("t2_limit_valid", 64'(bus.cmd_valid),   64'd0);
        chk("t2_limit_out",   64'(bus.outstanding), 64'd4);
        tick();
        chk("t2_limit_hold_valid", 64'(bus.cmd_valid),   64'd0);
        chk("t2_limit_hold_out",   64'(bus.outstanding), 64'd4);
        bus.done_irq = 1'b1;
        tick();
        bus.done_irq = 1'b0;
        chk("t2_no_bypass_valid", 64'(bus.cmd_valid),   64'd0);
        chk("t2_done_out",        64'(bus.outstanding), 64'd3);
        tick();
        chk("t2_tile4_valid", 64'(bus.cmd_valid), 64'd1);
        chk("t2_tile4",       bus.cmd_data,       exp6[4]);
        bus.done_irq = 1'b1;
        tick();
        bus.done_irq = 1'b0;
        chk("t2_coincident_out",   64'(bus.outstanding), 64'd3);
        chk("t2_coincident_valid", 64'(bus.cmd_valid),   64'd0);
        bus.cmd_ready = 1'b0;
        tick();
        chk("t2_tile5_valid", 64'(bus.cmd_valid), 64'd1);
        chk("t2_tile5",       bus.cmd_data,       exp6[5]);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk($sformatf("t2_stall_valid%0d", i), 64'(bus.cmd_valid), 64'd1);
            chk($sformatf("t2_stall_data%0d", i),  bus.cmd_data,       exp6[5]);
        end
        bus.cmd_ready = 1'b1;
        tick();
        chk("t2_last_xfer_valid", 64'(bus.cmd_valid),   64'd0);
        chk("t2_last_xfer_out",   64'(bus.outstanding), 64'd4);
        chk("t2_drain_busy",      64'(bus.issuer_busy), 64'd1);
        chk("t2_drain_not_ready", 64'(bus.job_ready),   64'd0);
        bus.done_irq = 1'b1;
        for (int i = 3; i > 0; i--) begin
            tick();
            chk($sformatf("t2_drain_out%0d", i), 64'(bus.outstanding), 64'(i));
            chk($sformatf("t2_drain_nodone%0d", i), 64'(bus.job_done), 64'd0);
        end
        tick();
        chk("t2_drain_out_zero", 64'(bus.outstanding), 64'd0);
        chk("t2_job_done",       64'(bus.job_done),    64'd1);
        chk("t2_job_ready",      64'(bus.job_ready),   64'd1);
        tick();
        bus.done_irq = 1'b0;
        chk("t2_done_saturate", 64'(bus.outstanding), 64'd0);
        chk("t2_done_pulse",    64'(bus.job_done),    64'd0);

        // ---- rejected jobs ----
        set_job(8'd16, 8'd16, 8'd17, 10'h000, 10'h000, 10'h000, 10'h000);
        bus.job_valid = 1'b1;
        tick();
        bus.job_valid = 1'b0;
        chk("t3_k17_err",   64'(bus.job_err),   64'd1);
        chk("t3_k17_valid", 64'(bus.cmd_valid), 64'd0);
        chk("t3_k17_ready", 64'(bus.job_ready), 64'd1);
        tick();
        chk("t3_k17_err_pulse", 64'(bus.job_err),   64'd0);
        chk("t3_k17_valid2",    64'(bus.cmd_valid), 64'd0);
        set_job(8'd0, 8'd16, 8'd16, 10'h000, 10'h000, 10'h000, 10'h000);
        bus.job_valid = 1'b1;
        tick();
        bus.job_valid = 1'b0;
        chk("t3_m0_err",   64'(bus.job_err),     64'd1);
        chk("t3_m0_valid", 64'(bus.cmd_valid),   64'd0);
        chk("t3_m0_ready", 64'(bus.job_ready),   64'd1);
        chk("t3_m0_busy",  64'(bus.issuer_busy), 64'd0);
        tick();
        chk("t3_m0_err_pulse", 64'(bus.job_err),   64'd0);
        chk("t3_m0_valid2",    64'(bus.cmd_valid), 64'd0);

        // ---- address wrap: 16x32 job, base_d near the top ----
        set_job(8'd16, 8'd32, 8'd4, 10'h000, 10'h000, 10'h100, 10'h3F0);
        bus.job_valid = 1'b1;
        tick();
        bus.job_valid = 1'b0;
        chk("t4_tile0", bus.cmd_data,
            mk_cmd(10'h3F0, 10'h100, 10'h000, 10'h000, 8'd16, 8'd4, 8'd16));
        tick();
        chk("t4_tile1_wrap", bus.cmd_data,
            mk_cmd(10'h000, 10'h110, 10'h010, 10'h000, 8'd16, 8'd4, 8'd16));
        tick();
        chk("t4_valid_low", 64'(bus.cmd_valid),   64'd0);
        chk("t4_out2",      64'(bus.outstanding), 64'd2);
        bus.done_irq = 1'b1;
        tick();
        tick();
        bus.done_irq = 1'b0;
        chk("t4_job_done", 64'(bus.job_done), 64'd1);
        tick();

        // ---- async reset mid-ISSUE with three tiles in flight ----
        set_job(8'd40, 8'd20, 8'd8, 10'h000, 10'h040, 10'h080, 10'h200);
        bus.job_valid = 1'b1;
        tick();
        bus.job_valid = 1'b0;
        tick();
        tick();
        tick();
        chk("t5_pre_out3",   64'(bus.outstanding), 64'd3);
        chk("t5_pre_valid",  64'(bus.cmd_valid),   64'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("t5_rst_valid", 64'(bus.cmd_valid),   64'd0);
        chk("t5_rst_out",   64'(bus.outstanding), 64'd0);
        chk("t5_rst_ready", 64'(bus.job_ready),   64'd1);
        chk("t5_rst_busy",  64'(bus.issuer_busy), 64'd0);
        chk("t5_rst_data",  bus.cmd_data,         64'd0);
        tick();
        rst = 1'b0;
        tick();
        bus.job_valid = 1'b1;
        tick();
        bus.job_valid = 1'b0;
        chk("t5_restart_tile0", bus.cmd_data,         exp6[0]);
        chk("t5_restart_valid", 64'(bus.cmd_valid),   64'd1);
        chk("t5_restart_out",   64'(bus.outstanding), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
